countdown_timer_ctrl: RTL and testbench
=======================================

COUNTDOWN_TIMER_CTRL -- requirements
Module: countdown_timer_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 25000000, giving clock cycles per countdown tick (legal range 2 to 2^26-1).
REQ-002 The block SHALL have parameter START_ON_LOAD, default 0; when 1, LOAD also starts the countdown.
REQ-003 The block SHALL have port CLK, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RSTn, input, 1 bit, reset that is synchronous and active-low.
REQ-005 The block SHALL have port LOAD, input, 1 bit, a level that captures PRESET in IDLE or DONE.
REQ-006 The block SHALL have port PRESET, input, 8 bits, the two-digit BCD start value {tens, ones}.
REQ-007 The block SHALL have port START, input, 1 bit, which starts or resumes the countdown.
REQ-008 The block SHALL have port PAUSE, input, 1 bit, which suspends the countdown.
REQ-009 The block SHALL have port CLEAR, input, 1 bit, which aborts to IDLE with value 00.
REQ-010 The block SHALL have port COUNT_ONES, output, 4 bits, the current ones digit in BCD.
REQ-011 The block SHALL have port COUNT_TENS, output, 4 bits, the current tens digit in BCD.
REQ-012 The block SHALL have port RUNNING, output, 1 bit, high while in RUN.
REQ-013 The block SHALL have port DONE, output, 1 bit, high while in DONE.
REQ-014 The block SHALL have port DONE_PULSE, output, 1 bit, a one-cycle strobe on entry to DONE.

Function
REQ-015 The block SHALL use an FSM with states IDLE, RUN, PAUSED and DONE.
REQ-016 Command priority SHALL be CLEAR > LOAD > START > PAUSE when asserted in the same cycle.
REQ-017 CLEAR in any state SHALL give IDLE, digits 00 and prescaler 0 on the next edge.
REQ-018 LOAD in IDLE or DONE SHALL capture PRESET, with any digit >9 clamped to 9, and go to IDLE.
REQ-019 LOAD in IDLE or DONE with START_ON_LOAD=1 SHALL capture PRESET and go directly to RUN.
REQ-020 LOAD in RUN or PAUSED SHALL be ignored.
REQ-021 START in IDLE with nonzero digits SHALL go to RUN and zero the prescaler.
REQ-022 START in IDLE with digits 00 SHALL go to DONE and assert DONE_PULSE.
REQ-023 START in PAUSED SHALL go to RUN without resetting the prescaler, so the partial tick is preserved.
REQ-024 PAUSE in RUN SHALL go to PAUSED, with the prescaler and digits frozen.
REQ-025 START in RUN, PAUSE outside RUN, and START in DONE SHALL be ignored.
REQ-026 The prescaler SHALL advance only in RUN and SHALL produce a tick on its terminal count TICK_DIV-1, then wrap to 0.
REQ-027 On a tick, the digits SHALL decrement in BCD: ones 0 borrows from tens and becomes 9; otherwise ones decrements.
REQ-028 A tick that makes the digits 00 SHALL move the FSM to DONE on the same edge, and DONE_PULSE SHALL be high for the following cycle only.
REQ-029 The first tick after START from IDLE SHALL occur exactly TICK_DIV cycles after the START edge.
REQ-030 RUNNING and DONE SHALL be registered decodes of the state, with no combinational path from inputs to outputs.

Reset
REQ-031 When RSTn=0 at a rising edge, the block SHALL set state IDLE, digits 00, prescaler 0, RUNNING=0, DONE=0 and DONE_PULSE=0.
REQ-032 Reset SHALL override every command, including mid-RUN or mid-tick.
REQ-033 The captured preset SHALL also reset to 00.

Configuration
REQ-034 When macro TIMER_AUTO_RELOAD_EN is defined, reaching 00 in RUN SHALL reload the last captured preset and remain in RUN.
REQ-035 With TIMER_AUTO_RELOAD_EN defined, DONE_PULSE SHALL still strobe once per expiry and DONE SHALL stay 0 on expiry.
REQ-036 With TIMER_AUTO_RELOAD_EN defined and a captured preset of 00, START in IDLE SHALL behave as in REQ-022.
REQ-037 When TIMER_AUTO_RELOAD_EN is undefined, expiry SHALL behave as in REQ-028 and no reload register SHALL be synthesized.

Structure
REQ-038 Package timer_pkg SHALL hold the FSM state enum, BCD digit typedef, and constants BCD_MAX=9 and DIGITS=2.
REQ-039 The prescaler SHALL be an instance of the existing parametrizable module counter with modulus TICK_DIV, ENABLE=(state==RUN), and reset driven by RSTn and by the restart-from-IDLE condition.
REQ-040 The BCD decrement and the FSM SHALL remain in the top module.

Verification (TICK_DIV=4)
REQ-041 The bench SHALL check: LOAD PRESET=8'h12, then START -> digits 12,11,10,09 at +4,+8,+12 cycles, and the 10->09 borrow is correct.
REQ-042 The bench SHALL check: PRESET=8'h02, START -> DONE_PULSE for one cycle at +8, DONE=1, digits 00, RUNNING=0.
REQ-043 The bench SHALL check: PAUSE 2 cycles into a tick, hold 10 cycles, then START -> the next decrement occurs 2 cycles after resume.
REQ-044 The bench SHALL check: CLEAR, LOAD and START asserted together in RUN -> IDLE, digits 00.
REQ-045 The bench SHALL check: PRESET=8'hAF -> captured value 99; START with 00 -> immediate DONE plus DONE_PULSE.
REQ-046 The bench SHALL check: with TIMER_AUTO_RELOAD_EN defined and PRESET=8'h01 -> DONE_PULSE every 4 cycles, RUNNING stays 1, digits 01 after each pulse; RSTn=0 mid-run -> all outputs zero the next cycle.

Source files
------------

// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer.
package timer_pkg;

    localparam int unsigned BCD_MAX = 9;
    localparam int unsigned DIGITS  = 2;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Saturate an out-of-range BCD nibble to 9.
    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > bcd_t'(BCD_MAX)) ? bcd_t'(BCD_MAX) : d;
    endfunction

endpackage

// File: rtl/countdown_timer_ctrl_counter.sv
// Modulo-N enabled counter with synchronous active-low reset; o_tc_c flags the terminal count.
module counter #(
    parameter int unsigned MODULUS = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tc_c
);

    localparam int unsigned WIDTH = (MODULUS > 1) ? $clog2(MODULUS) : 1;

    logic [WIDTH-1:0] r_count;
    logic             w_at_tc;

    assign w_at_tc = (r_count == WIDTH'(MODULUS - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_at_tc ? '0 : r_count + WIDTH'(1);
        end
    end

    assign o_tc_c = i_en && w_at_tc;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Two-digit BCD countdown timer with IDLE/RUN/PAUSED/DONE control.
// Optional macro TIMER_AUTO_RELOAD_EN reloads the captured preset on expiry instead of stopping.
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 25000000,
    parameter bit          START_ON_LOAD = 1'b0
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       LOAD,
    input  logic [7:0] PRESET,
    input  logic       START,
    input  logic       PAUSE,
    input  logic       CLEAR,
    output logic [3:0] COUNT_ONES,
    output logic [3:0] COUNT_TENS,
    output logic       RUNNING,
    output logic       DONE,
    output logic       DONE_PULSE
);

    state_e r_state, w_state_next;
    bcd_t   r_ones, r_tens, w_ones_next, w_tens_next;
    bcd_t   w_load_ones, w_load_tens, w_dec_ones, w_dec_tens;
    logic   r_running, r_done, r_pulse;
    logic   w_pulse_next, w_restart, w_tick, w_cnt_rst_n;
    logic   w_cur_zero, w_load_zero, w_dec_zero;
    logic [DIGITS*4-1:0] w_load_val;

`ifdef TIMER_AUTO_RELOAD_EN
    bcd_t   r_pre_ones, r_pre_tens, w_pre_ones_next, w_pre_tens_next;
`endif

    assign w_load_val  = PRESET;
    assign w_load_ones = bcd_clamp(w_load_val[3:0]);
    assign w_load_tens = bcd_clamp(w_load_val[7:4]);
    assign w_load_zero = (w_load_ones == '0) && (w_load_tens == '0);
    assign w_cur_zero  = (r_ones == '0) && (r_tens == '0);

    // BCD decrement with borrow from the tens digit
    assign w_dec_ones = (r_ones == '0) ? bcd_t'(BCD_MAX) : r_ones - bcd_t'(1);
    assign w_dec_tens = (r_ones == '0) ? r_tens - bcd_t'(1) : r_tens;
    assign w_dec_zero = (w_dec_ones == '0) && (w_dec_tens == '0);

    // Prescaler restarts on reset, CLEAR, and any fresh start from IDLE/DONE
    assign w_cnt_rst_n = RSTn && !CLEAR && !w_restart;

    counter #(
        .MODULUS (TICK_DIV)
    ) u_prescaler (
        .i_clk   (CLK),
        .i_rst_n (w_cnt_rst_n),
        .i_en    (r_state == ST_RUN),
        .o_tc_c  (w_tick)
    );

    always_comb begin
        w_state_next = r_state;
        w_ones_next  = r_ones;
        w_tens_next  = r_tens;
        w_pulse_next = 1'b0;
        w_restart    = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
        w_pre_ones_next = r_pre_ones;
        w_pre_tens_next = r_pre_tens;
`endif
        if (CLEAR) begin
            w_state_next = ST_IDLE;
            w_ones_next  = '0;
            w_tens_next  = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (LOAD) begin
                        w_ones_next  = w_load_ones;
                        w_tens_next  = w_load_tens;
`ifdef TIMER_AUTO_RELOAD_EN
                        w_pre_ones_next = w_load_ones;
                        w_pre_tens_next = w_load_tens;
`endif
                        w_state_next = ST_IDLE;
                        if (START_ON_LOAD) begin
                            if (w_load_zero) begin
                                w_state_next = ST_DONE;
                                w_pulse_next = 1'b1;
                            end else begin
                                w_state_next = ST_RUN;
                                w_restart    = 1'b1;
                            end
                        end
                    end else if (START && (r_state == ST_IDLE)) begin
                        if (w_cur_zero) begin
                            w_state_next = ST_DONE;
                            w_pulse_next = 1'b1;
                        end else begin
                            w_state_next = ST_RUN;
                            w_restart    = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_tick) begin
                        w_ones_next = w_dec_ones;
                        w_tens_next = w_dec_tens;
                        if (w_dec_zero) begin
                            w_pulse_next = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                            w_ones_next  = r_pre_ones;
                            w_tens_next  = r_pre_tens;
`else
                            w_state_next = ST_DONE;
`endif
                        end
                    end
                    // Higher-priority LOAD/START are ignored in RUN but still mask PAUSE
                    if ((w_state_next == ST_RUN) && !LOAD && !START && PAUSE) begin
                        w_state_next = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (!LOAD && START) begin
                        w_state_next = ST_RUN;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Digits and registered status decodes
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_ones    <= '0;
            r_tens    <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_pulse   <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
            r_pre_ones <= '0;
            r_pre_tens <= '0;
`endif
        end else begin
            r_ones    <= w_ones_next;
            r_tens    <= w_tens_next;
            r_running <= (w_state_next == ST_RUN);
            r_done    <= (w_state_next == ST_DONE);
            r_pulse   <= w_pulse_next;
`ifdef TIMER_AUTO_RELOAD_EN
            r_pre_ones <= w_pre_ones_next;
            r_pre_tens <= w_pre_tens_next;
`endif
        end
    end

    assign COUNT_ONES = r_ones;
    assign COUNT_TENS = r_tens;
    assign RUNNING    = r_running;
    assign DONE       = r_done;
    assign DONE_PULSE = r_pulse;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl at TICK_DIV=4; honours TIMER_AUTO_RELOAD_EN when defined.
module tb_countdown_timer_ctrl;

    logic       CLK;
    logic       RSTn;
    logic       LOAD;
    logic [7:0] PRESET;
    logic       START;
    logic       PAUSE;
    logic       CLEAR;
    logic [3:0] COUNT_ONES;
    logic [3:0] COUNT_TENS;
    logic       RUNNING;
    logic       DONE;
    logic       DONE_PULSE;

    countdown_timer_ctrl #(
        .TICK_DIV      (4),
        .START_ON_LOAD (1'b0)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .LOAD       (LOAD),
        .PRESET     (PRESET),
        .START      (START),
        .PAUSE      (PAUSE),
        .CLEAR      (CLEAR),
        .COUNT_ONES (COUNT_ONES),
        .COUNT_TENS (COUNT_TENS),
        .RUNNING    (RUNNING),
        .DONE       (DONE),
        .DONE_PULSE (DONE_PULSE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // cmd = {reset, load, start, pause, clear}; st = {running, done, pulse}
    localparam logic [4:0] NOP = 5'b00000;
    localparam logic [4:0] CLR = 5'b00001;
    localparam logic [4:0] PAU = 5'b00010;
    localparam logic [4:0] STA = 5'b00100;
    localparam logic [4:0] LOD = 5'b01000;
    localparam logic [4:0] RST = 5'b10000;
    localparam logic [2:0] IDL = 3'b000;
    localparam logic [2:0] RN  = 3'b100;
    localparam logic [2:0] RNP = 3'b101;
    localparam logic [2:0] DN  = 3'b010;
    localparam logic [2:0] DNP = 3'b011;

    typedef struct {
        logic [4:0] cmd;
        logic [7:0] preset;
        logic [7:0] digits;
        logic [2:0] st;
    } vec_t;

    typedef struct {
        logic [7:0] digits;
        logic [2:0] st;
        int         id;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [4:0] c, input logic [7:0] p,
                                input logic [7:0] d, input logic [2:0] s);
        vec_t v;
        v.cmd = c; v.preset = p; v.digits = d; v.st = s;
        return v;
    endfunction

    task automatic check_out();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected entry for observed output");
        end else begin
            e = sb.pop_front();
            if (({COUNT_TENS, COUNT_ONES} !== e.digits) ||
                ({RUNNING, DONE, DONE_PULSE} !== e.st)) begin
                errors++;
                $display("FAIL step%0d: got digits=%h run/done/pulse=%b, expected digits=%h run/done/pulse=%b",
                         e.id, {COUNT_TENS, COUNT_ONES}, {RUNNING, DONE, DONE_PULSE}, e.digits, e.st);
            end
        end
    endtask

    task automatic drive(input vec_t v, input int id);
        exp_t e;
        RSTn   = ~v.cmd[4];
        LOAD   = v.cmd[3];
        START  = v.cmd[2];
        PAUSE  = v.cmd[1];
        CLEAR  = v.cmd[0];
        PRESET = v.preset;
        e.digits = v.digits; e.st = v.st; e.id = id;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        check_out();
    endtask

    task automatic nops(input int n, input logic [7:0] d, input logic [2:0] s, input int id);
        for (int i = 0; i < n; i++) drive(mk(NOP, 8'h00, d, s), id + i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int id;
        RSTn = 1'b0; LOAD = 1'b0; START = 1'b0; PAUSE = 1'b0; CLEAR = 1'b0; PRESET = 8'h00;

        // Reset, load 12, countdown through the 10->09 borrow, combined commands, clamping, zero start
        tbl.push_back(mk(RST, 8'h00, 8'h00, IDL));
        tbl.push_back(mk(LOD, 8'h12, 8'h12, IDL));
        tbl.push_back(mk(STA, 8'h00, 8'h12, RN));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(NOP, 8'h00, 8'h12, RN));
        tbl.push_back(mk(NOP, 8'h00, 8'h11, RN));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(NOP, 8'h00, 8'h11, RN));
        tbl.push_back(mk(NOP, 8'h00, 8'h10, RN));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(NOP, 8'h00, 8'h10, RN));
        tbl.push_back(mk(NOP, 8'h00, 8'h09, RN));
        tbl.push_back(mk(NOP, 8'h00, 8'h09, RN));
        tbl.push_back(mk(CLR | LOD | STA, 8'h55, 8'h00, IDL));
        tbl.push_back(mk(NOP, 8'h00, 8'h00, IDL));
        tbl.push_back(mk(LOD, 8'hAF, 8'h99, IDL));
        tbl.push_back(mk(CLR, 8'h00, 8'h00, IDL));
        tbl.push_back(mk(STA, 8'h00, 8'h00, DNP));
        tbl.push_back(mk(NOP, 8'h00, 8'h00, DN));
        tbl.push_back(mk(STA, 8'h00, 8'h00, DN));
        tbl.push_back(mk(PAU, 8'h00, 8'h00, DN));
        tbl.push_back(mk(LOD, 8'h34, 8'h34, IDL));
        tbl.push_back(mk(PAU, 8'h00, 8'h34, IDL));

        foreach (tbl[i]) drive(tbl[i], i);

        // Expiry from 02
        id = 100;
        drive(mk(CLR, 8'h00, 8'h00, IDL), id++);
        drive(mk(LOD, 8'h02, 8'h02, IDL), id++);
        drive(mk(STA, 8'h00, 8'h02, RN), id++);
        nops(3, 8'h02, RN, id); id += 3;
        drive(mk(NOP, 8'h00, 8'h01, RN), id++);
        nops(3, 8'h01, RN, id); id += 3;
`ifdef TIMER_AUTO_RELOAD_EN
        drive(mk(NOP, 8'h00, 8'h02, RNP), id++);
        drive(mk(NOP, 8'h00, 8'h02, RN), id++);
`else
        drive(mk(NOP, 8'h00, 8'h00, DNP), id++);
        drive(mk(NOP, 8'h00, 8'h00, DN), id++);
`endif

`ifdef TIMER_AUTO_RELOAD_EN
        // Auto-reload of 01: pulse every 4 cycles, then reset mid-run
        id = 300;
        drive(mk(CLR, 8'h00, 8'h00, IDL), id++);
        drive(mk(LOD, 8'h01, 8'h01, IDL), id++);
        drive(mk(STA, 8'h00, 8'h01, RN), id++);
        for (int k = 0; k < 3; k++) begin
            nops(3, 8'h01, RN, id); id += 3;
            drive(mk(NOP, 8'h00, 8'h01, RNP), id++);
        end
        nops(2, 8'h01, RN, id); id += 2;
        drive(mk(RST, 8'h00, 8'h00, IDL), id++);
        drive(mk(NOP, 8'h00, 8'h00, IDL), id++);
`endif

        // Pause two cycles into a tick, hold, resume; then reset mid-tick
        id = 200;
        drive(mk(CLR, 8'h00, 8'h00, IDL), id++);
        drive(mk(LOD, 8'h12, 8'h12, IDL), id++);
        drive(mk(STA, 8'h00, 8'h12, RN), id++);
        drive(mk(NOP, 8'h00, 8'h12, RN), id++);
        drive(mk(PAU, 8'h00, 8'h12, IDL), id++);
        nops(10, 8'h12, IDL, id); id += 10;
        drive(mk(STA, 8'h00, 8'h12, RN), id++);
        drive(mk(NOP, 8'h00, 8'h12, RN), id++);
        drive(mk(NOP, 8'h00, 8'h11, RN), id++);
        nops(3, 8'h11, RN, id); id += 3;
        drive(mk(NOP, 8'h00, 8'h10, RN), id++);
        drive(mk(NOP, 8'h00, 8'h10, RN), id++);
        drive(mk(RST | STA | LOD, 8'h77, 8'h00, IDL), id++);
        drive(mk(NOP, 8'h00, 8'h00, IDL), id++);
        drive(mk(STA, 8'h00, 8'h00, DNP), id++);
        drive(mk(NOP, 8'h00, 8'h00, DN), id++);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
